// File: rtl/rocc_mem_pkg.sv
// Shared constants, response payload type and load-extract helpers for the RoCC memory responder.
package rocc_mem_pkg;

  localparam int unsigned MemAddrW = 40;
  localparam int unsigned MemTagW  = 10;

  localparam logic [4:0] M_XRD = 5'h00;
  localparam logic [4:0] M_XWR = 5'h01;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_D  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  localparam logic [2:0] MT_WU = 3'd6;

  typedef struct packed {
    logic [MemAddrW-1:0] addr;
    logic [MemTagW-1:0]  tag;
    logic [4:0]          cmd;
    logic [2:0]          typ;
    logic [63:0]         data;
    logic                has_data;
    logic [63:0]         word_bypass;
    logic [63:0]         store_data;
    logic                nack;
  } mem_resp_t;

  // Access size in bytes; the illegal typ 7 reports 8 and is nacked by the caller.
  function automatic logic [3:0] size_of(input logic [2:0] typ);
    case (typ)
      MT_B, MT_BU: return 4'd1;
      MT_H, MT_HU: return 4'd2;
      MT_W, MT_WU: return 4'd4;
      default:     return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] word, input logic [2:0] off,
                                         input logic [2:0] typ);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (typ)
      MT_B:    return {{56{sh[7]}}, sh[7:0]};
      MT_H:    return {{48{sh[15]}}, sh[15:0]};
      MT_W:    return {{32{sh[31]}}, sh[31:0]};
      MT_BU:   return {56'd0, sh[7:0]};
      MT_HU:   return {48'd0, sh[15:0]};
      MT_WU:   return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/rocc_mem_responder_if.sv
// RoCC mem_req / mem_resp bundle; master is the accelerator, slave is the memory responder.
interface rocc_mem_responder_if #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned TAG_W  = 10
);

  logic              mem_req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W-1:0]  mem_req_tag;
  logic [4:0]        mem_req_cmd;
  logic [2:0]        mem_req_typ;
  logic              mem_req_phys;
  logic [63:0]       mem_req_data;

  logic              mem_resp_valid;
  logic [ADDR_W-1:0] mem_resp_addr;
  logic [TAG_W-1:0]  mem_resp_tag;
  logic [4:0]        mem_resp_cmd;
  logic [2:0]        mem_resp_typ;
  logic [63:0]       mem_resp_data;
  logic              mem_resp_has_data;
  logic [63:0]       mem_resp_data_word_bypass;
  logic [63:0]       mem_resp_store_data;
  logic              mem_resp_nack;
  logic              mem_resp_replay;

  modport master (
    input  mem_req_ready,
    output mem_req_valid, mem_req_addr, mem_req_tag, mem_req_cmd, mem_req_typ, mem_req_phys,
    output mem_req_data,
    input  mem_resp_valid, mem_resp_addr, mem_resp_tag, mem_resp_cmd, mem_resp_typ,
    input  mem_resp_data, mem_resp_has_data, mem_resp_data_word_bypass, mem_resp_store_data,
    input  mem_resp_nack, mem_resp_replay
  );

  modport slave (
    output mem_req_ready,
    input  mem_req_valid, mem_req_addr, mem_req_tag, mem_req_cmd, mem_req_typ, mem_req_phys,
    input  mem_req_data,
    output mem_resp_valid, mem_resp_addr, mem_resp_tag, mem_resp_cmd, mem_resp_typ,
    output mem_resp_data, mem_resp_has_data, mem_resp_data_word_bypass, mem_resp_store_data,
    output mem_resp_nack, mem_resp_replay
  );

endinterface

// File: rtl/rocc_mem_resp_pipe.sv
// Fixed-latency response shift register; payload stages only load on a valid so the output
// payload holds the last emitted response through bubbles.
module rocc_mem_resp_pipe #(
  parameter int unsigned LAT = 2,
  parameter type         T   = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  logic [LAT-1:0] valid_d, valid_q;
  T               data_d [LAT];
  T               data_q [LAT];

  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = valid_i ? data_i : data_q[0];
    for (int unsigned i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/rocc_mem_responder.sv
// RoCC memory responder: 64-bit word array with byte-lane stores, extended loads, request
// validation and a fixed-latency in-order response pipeline.
module rocc_mem_responder
  import rocc_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned LAT    = 2,
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned TAG_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  rocc_mem_responder_if.slave  mem
);

  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(DEPTH * 8);

  logic [63:0]     mem_q [DEPTH];
  logic [IdxW-1:0] idx;
  logic [2:0]      off;
  logic [5:0]      sh;
  logic [3:0]      size;
  logic            in_range, misaligned, cmd_ok, nack, is_store, accept;
  logic [63:0]     word, size_mask, lane_mask, lane_data;
  mem_resp_t       resp_in, resp_out;
  logic            resp_valid;
  logic            unused_phys;

  assign unused_phys       = mem.mem_req_phys;
  assign mem.mem_req_ready = ~stall_i;
  // Nothing is accepted while reset is held, even though ready is still driven.
  assign accept            = mem.mem_req_valid & ~stall_i & rst;

  always_comb begin
    off        = mem.mem_req_addr[2:0];
    sh         = {off, 3'b000};
    idx        = mem.mem_req_addr[IdxW+2:3];
    size       = size_of(mem.mem_req_typ);
    in_range   = mem.mem_req_addr < AddrLimit;
    misaligned = |(off & 3'(size - 4'd1));
    cmd_ok     = (mem.mem_req_cmd == M_XRD) || (mem.mem_req_cmd == M_XWR);
    nack       = !in_range || misaligned || !cmd_ok || (mem.mem_req_typ == 3'd7);
    is_store   = mem.mem_req_cmd == M_XWR;
    word       = in_range ? mem_q[idx] : '0;
    case (size)
      4'd1:    size_mask = 64'h0000_0000_0000_00ff;
      4'd2:    size_mask = 64'h0000_0000_0000_ffff;
      4'd4:    size_mask = 64'h0000_0000_ffff_ffff;
      default: size_mask = '1;
    endcase
    lane_mask = size_mask << sh;
    lane_data = (mem.mem_req_data & size_mask) << sh;

    resp_in             = '0;
    resp_in.addr        = MemAddrW'(mem.mem_req_addr);
    resp_in.tag         = MemTagW'(mem.mem_req_tag);
    resp_in.cmd         = mem.mem_req_cmd;
    resp_in.typ         = mem.mem_req_typ;
    resp_in.has_data    = !nack && !is_store;
    resp_in.data        = resp_in.has_data ? extend(word, off, mem.mem_req_typ) : '0;
    resp_in.word_bypass = word;
    resp_in.store_data  = mem.mem_req_data;
    resp_in.nack        = nack;
  end

  // Array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && is_store && !nack) begin
      mem_q[idx] <= (word & ~lane_mask) | lane_data;
    end
  end

  rocc_mem_resp_pipe #(
    .LAT (LAT),
    .T   (mem_resp_t)
  ) u_pipe (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (accept),
    .data_i  (resp_in),
    .valid_o (resp_valid),
    .data_o  (resp_out)
  );

  assign mem.mem_resp_valid            = resp_valid;
  assign mem.mem_resp_addr             = ADDR_W'(resp_out.addr);
  assign mem.mem_resp_tag              = TAG_W'(resp_out.tag);
  assign mem.mem_resp_cmd              = resp_out.cmd;
  assign mem.mem_resp_typ              = resp_out.typ;
  assign mem.mem_resp_data             = resp_out.data;
  assign mem.mem_resp_has_data         = resp_out.has_data;
  assign mem.mem_resp_data_word_bypass = resp_out.word_bypass;
  assign mem.mem_resp_store_data       = resp_out.store_data;
  assign mem.mem_resp_nack             = resp_out.nack;
  assign mem.mem_resp_replay           = 1'b0;

endmodule

// File: tb/tb_rocc_mem_responder.sv
// Directed bench for rocc_mem_responder: stores/loads, extension, nacks, stall, ordering, reset.
module tb_rocc_mem_responder;
  import rocc_mem_pkg::*;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;

  typedef struct {
    int          cyc;
    logic [9:0]  tag;
    logic [63:0] data;
    logic        nack;
    logic        has_data;
    logic [63:0] bypass;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall_i = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rec_t rq[$];

  rocc_mem_responder_if #(.ADDR_W(40), .TAG_W(10)) mif ();

  rocc_mem_responder #(
    .DEPTH  (Depth),
    .LAT    (Lat),
    .ADDR_W (40),
    .TAG_W  (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_i),
    .mem     (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mif.mem_resp_valid === 1'b1) begin
      rq.push_back('{cyc: cyc, tag: mif.mem_resp_tag, data: mif.mem_resp_data,
                     nack: mif.mem_resp_nack, has_data: mif.mem_resp_has_data,
                     bypass: mif.mem_resp_data_word_bypass});
    end
  end

  // Presents one request and returns the cycle count of its accept edge (ready assumed high).
  task automatic send(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                      input logic [9:0] tag, input logic [63:0] data, output int acc);
    mif.mem_req_valid = 1'b1;
    mif.mem_req_cmd   = cmd;
    mif.mem_req_typ   = typ;
    mif.mem_req_addr  = addr;
    mif.mem_req_tag   = tag;
    mif.mem_req_data  = data;
    @(posedge clk);
    #1;
    acc = cyc;
    mif.mem_req_valid = 1'b0;
  endtask

  task automatic get_resp(output rec_t r, output bit got);
    int n = 0;
    got = 1'b0;
    r = '{cyc: -1, tag: '0, data: '0, nack: 1'b0, has_data: 1'b0, bypass: '0};
    while (rq.size() == 0 && n < 16) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (rq.size() != 0) begin
      r = rq.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic xact(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                      input logic [9:0] tag, input logic [63:0] data, output rec_t r,
                      output bit got, output int acc);
    send(cmd, typ, addr, tag, data, acc);
    get_resp(r, got);
  endtask

  task automatic test_reset();
    int acc;
    mif.mem_req_valid = 1'b0;
    mif.mem_req_phys  = 1'b0;
    mif.mem_req_cmd   = M_XRD;
    mif.mem_req_typ   = MT_D;
    mif.mem_req_addr  = '0;
    mif.mem_req_tag   = '0;
    mif.mem_req_data  = '0;
    stall_i = 1'b1;
    #3;
    checks++;
    if (mif.mem_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_stall: got %b expected 0", mif.mem_req_ready);
    end
    stall_i = 1'b0;
    #1;
    checks++;
    if (mif.mem_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", mif.mem_req_ready);
    end
    // A request offered during reset must never be accepted.
    send(M_XRD, MT_D, 40'h10, 10'h3ff, 64'h0, acc);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 0 || mif.mem_resp_valid !== 1'b0 || mif.mem_resp_data !== 64'h0 ||
        mif.mem_resp_tag !== 10'h0 || mif.mem_resp_nack !== 1'b0 ||
        mif.mem_resp_replay !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid %b data %h tag %h nack %b resps %0d expected all 0",
               mif.mem_resp_valid, mif.mem_resp_data, mif.mem_resp_tag, mif.mem_resp_nack,
               rq.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load_d();
    rec_t r; bit got; int acc;
    xact(M_XWR, MT_D, 40'h10, 10'h005, 64'h0123_4567_89ab_cdef, r, got, acc);
    checks++;
    if (!got || r.cyc != acc + Lat - 1) begin
      errors++; $display("FAIL store_d_latency: got cyc %0d expected %0d", r.cyc, acc + Lat - 1);
    end
    checks++;
    if (r.tag !== 10'h005 || r.nack !== 1'b0 || r.has_data !== 1'b0 || r.data !== 64'h0) begin
      errors++;
      $display("FAIL store_d_resp: tag %h nack %b has_data %b data %h expected 005 0 0 0",
               r.tag, r.nack, r.has_data, r.data);
    end
    xact(M_XRD, MT_D, 40'h10, 10'h006, 64'h0, r, got, acc);
    checks++;
    if (!got || r.cyc != acc + Lat - 1) begin
      errors++; $display("FAIL load_d_latency: got cyc %0d expected %0d", r.cyc, acc + Lat - 1);
    end
    checks++;
    if (r.data !== 64'h0123_4567_89ab_cdef || r.has_data !== 1'b1 || r.tag !== 10'h006) begin
      errors++;
      $display("FAIL load_d_data: data %h has_data %b tag %h expected 0123456789abcdef 1 006",
               r.data, r.has_data, r.tag);
    end
  endtask

  task automatic test_byte_ext();
    rec_t r; bit got; int acc;
    xact(M_XWR, MT_D, 40'h20, 10'h010, 64'h8111_2222_f333_4444, r, got, acc);
    xact(M_XWR, MT_B, 40'h21, 10'h011, 64'h1234_5678_9abc_de80, r, got, acc);
    xact(M_XRD, MT_B, 40'h21, 10'h012, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'hffff_ffff_ffff_ff80) begin
      errors++; $display("FAIL load_b: got %h expected ffffffffffffff80", r.data);
    end
    checks++;
    if (r.bypass !== 64'h8111_2222_f333_8044) begin
      errors++; $display("FAIL bypass_word: got %h expected 81112222f3338044", r.bypass);
    end
    xact(M_XRD, MT_BU, 40'h21, 10'h013, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'h80) begin
      errors++; $display("FAIL load_bu: got %h expected 0000000000000080", r.data);
    end
    xact(M_XRD, MT_W, 40'h20, 10'h014, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'hffff_ffff_f333_8044) begin
      errors++; $display("FAIL load_w: got %h expected fffffffff3338044", r.data);
    end
    xact(M_XRD, MT_WU, 40'h20, 10'h015, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'h0000_0000_f333_8044) begin
      errors++; $display("FAIL load_wu: got %h expected 00000000f3338044", r.data);
    end
    xact(M_XRD, MT_H, 40'h26, 10'h016, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'hffff_ffff_ffff_8111) begin
      errors++; $display("FAIL load_h: got %h expected ffffffffffff8111", r.data);
    end
    xact(M_XRD, MT_HU, 40'h24, 10'h017, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'h2222) begin
      errors++; $display("FAIL load_hu: got %h expected 0000000000002222", r.data);
    end
  endtask

  task automatic test_nack();
    rec_t r; bit got; int acc;
    xact(M_XWR, MT_D, 40'h7f8, 10'h020, 64'h5a5a_a5a5_0f0f_f0f0, r, got, acc);
    xact(M_XWR, MT_D, 40'h0, 10'h021, 64'h0f0f_1e1e_2d2d_3c3c, r, got, acc);
    xact(M_XRD, MT_W, 40'h22, 10'h022, 64'h0, r, got, acc);
    checks++;
    if (!got || r.nack !== 1'b1 || r.has_data !== 1'b0 || r.data !== 64'h0) begin
      errors++; $display("FAIL nack_misaligned: nack %b has_data %b data %h expected 1 0 0",
                         r.nack, r.has_data, r.data);
    end
    xact(M_XWR, MT_D, 40'(Depth * 8), 10'h023, 64'hdead_dead_dead_dead, r, got, acc);
    checks++;
    if (!got || r.nack !== 1'b1 || r.tag !== 10'h023) begin
      errors++; $display("FAIL nack_range: nack %b tag %h expected 1 023", r.nack, r.tag);
    end
    xact(M_XRD, MT_D, 40'h7f8, 10'h024, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'h5a5a_a5a5_0f0f_f0f0 || r.nack !== 1'b0) begin
      errors++; $display("FAIL top_word_kept: got %h expected 5a5aa5a50f0ff0f0", r.data);
    end
    xact(M_XRD, MT_D, 40'h0, 10'h025, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'h0f0f_1e1e_2d2d_3c3c) begin
      errors++; $display("FAIL word0_kept: got %h expected 0f0f1e1e2d2d3c3c", r.data);
    end
    xact(5'h07, MT_D, 40'h10, 10'h026, 64'h0, r, got, acc);
    checks++;
    if (!got || r.nack !== 1'b1 || r.has_data !== 1'b0) begin
      errors++; $display("FAIL nack_cmd: nack %b has_data %b expected 1 0", r.nack, r.has_data);
    end
    xact(M_XRD, 3'd7, 40'h10, 10'h027, 64'h0, r, got, acc);
    checks++;
    if (!got || r.nack !== 1'b1 || r.data !== 64'h0) begin
      errors++; $display("FAIL nack_typ7: nack %b data %h expected 1 0", r.nack, r.data);
    end
  endtask

  task automatic test_stall();
    rec_t r; bit got; int acc;
    stall_i = 1'b1;
    mif.mem_req_valid = 1'b1;
    mif.mem_req_cmd   = M_XRD;
    mif.mem_req_typ   = MT_D;
    mif.mem_req_addr  = 40'h10;
    mif.mem_req_tag   = 10'h044;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mif.mem_req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready: got %b expected 0", mif.mem_req_ready);
      end
    end
    repeat (Lat + 1) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL stall_no_resp: got %0d resps expected 0", rq.size());
    end
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    mif.mem_req_valid = 1'b0;
    get_resp(r, got);
    checks++;
    if (!got || r.tag !== 10'h044 || r.cyc != acc + Lat - 1 ||
        r.data !== 64'h0123_4567_89ab_cdef) begin
      errors++; $display("FAIL stall_release: tag %h cyc %0d data %h expected 044 %0d",
                         r.tag, r.cyc, r.data, acc + Lat - 1);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL stall_single: got %0d extra resps expected 0", rq.size());
    end
  endtask

  task automatic test_back_to_back();
    rec_t r; bit got;
    int acc [4];
    for (int i = 0; i < 4; i++) send(M_XRD, MT_D, 40'h10, 10'(i + 1), 64'h0, acc[i]);
    for (int i = 0; i < 4; i++) begin
      get_resp(r, got);
      checks++;
      if (!got || r.tag !== 10'(i + 1) || r.cyc != acc[i] + Lat - 1 ||
          r.data !== 64'h0123_4567_89ab_cdef) begin
        errors++; $display("FAIL b2b_%0d: tag %h cyc %0d expected tag %0d cyc %0d",
                           i, r.tag, r.cyc, i + 1, acc[i] + Lat - 1);
      end
    end
  endtask

  task automatic test_reset_midflight();
    rec_t r; bit got; int acc;
    xact(M_XWR, MT_D, 40'h30, 10'h030, 64'hcafe_babe_dead_beef, r, got, acc);
    send(M_XRD, MT_D, 40'h30, 10'h03a, 64'h0, acc);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mif.mem_resp_valid !== 1'b0 || mif.mem_resp_tag !== 10'h0 ||
        mif.mem_resp_store_data !== 64'h0 || mif.mem_resp_data_word_bypass !== 64'h0 ||
        mif.mem_resp_addr !== 40'h0) begin
      errors++; $display("FAIL midreset_outputs: valid %b tag %h store_data %h expected 0",
                         mif.mem_resp_valid, mif.mem_resp_tag, mif.mem_resp_store_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (Lat + 3) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 0 || mif.mem_resp_tag !== 10'h0) begin
      errors++; $display("FAIL midreset_dropped: got %0d resps tag %h expected 0",
                         rq.size(), mif.mem_resp_tag);
    end
    rq.delete();
    xact(M_XRD, MT_D, 40'h30, 10'h03b, 64'h0, r, got, acc);
    checks++;
    if (!got || r.data !== 64'hcafe_babe_dead_beef || r.tag !== 10'h03b) begin
      errors++; $display("FAIL midreset_store_kept: got %h expected cafebabedeadbeef", r.data);
    end
  endtask

  initial begin
    test_reset();
    test_store_load_d();
    test_byte_ext();
    test_nack();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
